// File: rtl/boolean_pkg.sv
// boolean_pkg: shared constants for the boolean_pipe slice.
//   WIDTH_DEFAULT  default operand/result width
//   ALUFN_*        truth-table codes; result bit = alufn[{b_bit, a_bit}]
package boolean_pkg;

   localparam int WIDTH_DEFAULT = 32;

   localparam logic [3:0] ALUFN_AND = 4'b1000;
   localparam logic [3:0] ALUFN_OR  = 4'b1110;
   localparam logic [3:0] ALUFN_XOR = 4'b0110;
   localparam logic [3:0] ALUFN_A   = 4'b1010;
   localparam logic [3:0] ALUFN_B   = 4'b1100;

endpackage

// File: rtl/boolean_pipe_stage.sv
// boolean_pipe_stage: generic valid/ready register slice.
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   upstream handshake
//   in_data [DW]          upstream payload
//   out_valid / out_ready downstream handshake
//   out_data [DW]         registered payload, cleared on reset
// in_ready looks through to out_ready so a full slice still accepts
// when it is emptying in the same cycle (no bubble at full rate).
module boolean_pipe_stage
   import boolean_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic load;

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/boolean_pipe.sv
// boolean_pipe: two-stage bitwise boolean unit with valid/ready handshakes.
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        operand handshake
//   in_alufn[4]              truth table, result bit = alufn[{b_bit, a_bit}]
//   in_chain                 use previous result in place of in_a
//   in_a, in_b [WIDTH]       operands
//   out_valid/out_ready      result handshake
//   out_result [WIDTH]       result
//   out_zero, out_ones       result==0 / result all ones (only when
//                            BOOLEAN_PIPE_FLAGS_EN is defined)
// S1 holds the raw operands; the boolean op is evaluated on the S1->S2
// transfer, so acc (last computed result) is always the result of the
// transaction accepted just before the one in S1.
module boolean_pipe
   import boolean_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_alufn,
   input  logic             in_chain,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef BOOLEAN_PIPE_FLAGS_EN
   output logic             out_zero,
   output logic             out_ones,
`endif
   output logic [WIDTH-1:0] out_result
);

   localparam int S1W = 4 + 1 + 2*WIDTH;
`ifdef BOOLEAN_PIPE_FLAGS_EN
   localparam int S2W = WIDTH + 2;
`else
   localparam int S2W = WIDTH;
`endif

   logic             s1_valid;
   logic [S1W-1:0]   s1_data;
   logic             s2_in_ready;
   logic             s2_load;
   logic [S2W-1:0]   s2_in;
   logic [S2W-1:0]   s2_data;

   logic [3:0]       s1_alufn;
   logic             s1_chain;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] acc;

   boolean_pipe_stage #(.DW(S1W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_alufn, in_chain, in_a, in_b}),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_data)
   );

   assign s1_alufn = s1_data[S1W-1 -: 4];
   assign s1_chain = s1_data[2*WIDTH];
   assign s1_a     = s1_data[2*WIDTH-1 -: WIDTH];
   assign s1_b     = s1_data[WIDTH-1:0];

   always_comb begin
      a_eff  = s1_chain ? acc : s1_a;
      result = '0;
      for (int i = 0; i < WIDTH; i++) begin
         result[i] = s1_alufn[{s1_b[i], a_eff[i]}];
      end
   end

`ifdef BOOLEAN_PIPE_FLAGS_EN
   assign s2_in = {(result == '0), (result == '1), result};
`else
   assign s2_in = result;
`endif

   boolean_pipe_stage #(.DW(S2W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   (s2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_data)
   );

   assign s2_load = s1_valid && s2_in_ready;

   // acc follows acceptance order, not retirement, so a chained op still
   // sees its predecessor's result after that result has left S2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (s2_load) begin
         acc <= result;
      end
   end

   assign out_result = s2_data[WIDTH-1:0];
`ifdef BOOLEAN_PIPE_FLAGS_EN
   assign out_zero = s2_data[WIDTH+1];
   assign out_ones = s2_data[WIDTH];
`endif

endmodule

// File: tb/tb_boolean_pipe.sv
module tb_boolean_pipe;
   import boolean_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_chain;
   logic [3:0]   in_alufn;
   logic [W-1:0] in_a, in_b, out_result;
   logic         out_valid, out_ready;
`ifdef BOOLEAN_PIPE_FLAGS_EN
   logic         out_zero, out_ones;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model: in-flight results in acceptance order
   logic [W-1:0] m_acc;
   logic [W-1:0] q_res[$];
   int           q_cyc[$];
   logic         last_acc;

   // optional directed expectation for the current cycle
   logic         dir_en;
   logic [W-1:0] dir_val;

   always #5 clk = ~clk;

   boolean_pipe #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_alufn   (in_alufn),
      .in_chain   (in_chain),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef BOOLEAN_PIPE_FLAGS_EN
      .out_zero   (out_zero),
      .out_ones   (out_ones),
`endif
      .out_result (out_result)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // sum of minterms selected by the truth table
   function automatic logic [W-1:0] ref_op(input logic [3:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      if (f[0]) r = r | (~a & ~b);
      if (f[1]) r = r | ( a & ~b);
      if (f[2]) r = r | (~a &  b);
      if (f[3]) r = r | ( a &  b);
      return r;
   endfunction

   // called just after a falling edge with inputs already driven
   task automatic cycle();
      logic         exp_ready, exp_valid;
      logic [W-1:0] a_eff;
      #1;
      exp_ready = (q_res.size() < 2) || out_ready;
      exp_valid = (q_res.size() > 0) && (q_cyc[0] <= cyc - 2);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         check("out_result", out_result, q_res[0]);
`ifdef BOOLEAN_PIPE_FLAGS_EN
         check("out_zero", out_zero, q_res[0] == '0);
         check("out_ones", out_ones, q_res[0] == '1);
`endif
      end
      if (dir_en) begin
         check("directed_valid", out_valid, 1'b1);
         check("directed_result", out_result, dir_val);
      end
      last_acc = in_valid && exp_ready;
      if (exp_valid && out_ready) begin
         void'(q_res.pop_front());
         void'(q_cyc.pop_front());
      end
      if (last_acc) begin
         a_eff = in_chain ? m_acc : in_a;
         m_acc = ref_op(in_alufn, a_eff, in_b);
         q_res.push_back(m_acc);
         q_cyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic step(input logic iv, input logic [3:0] f, input logic ch,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy,
                       input logic de, input logic [W-1:0] dv);
      in_valid  = iv;
      in_alufn  = f;
      in_chain  = ch;
      in_a      = a;
      in_b      = b;
      out_ready = ordy;
      dir_en    = de;
      dir_val   = dv;
      cycle();
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
   endtask

   initial begin
      int idx;
      logic [3:0]   ops_f[3];
      logic [W-1:0] ops_a[3];
      logic [W-1:0] ops_b[3];

      rst = 1'b1;
      in_valid = 1'b0; in_alufn = '0; in_chain = 1'b0; in_a = '0; in_b = '0;
      out_ready = 1'b1; dir_en = 1'b0; dir_val = '0;
      m_acc = '0; last_acc = 1'b0;
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_result", out_result, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // single AND, result two cycles after accept
      step(1'b1, ALUFN_AND, 1'b0, 8'hF0, 8'h3C, 1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'h30);
      drain();

      // back-to-back OR, XOR, B
      step(1'b1, ALUFN_OR,  1'b0, 8'hA5, 8'h0F, 1'b1, 1'b0, '0);
      step(1'b1, ALUFN_XOR, 1'b0, 8'hA5, 8'h0F, 1'b1, 1'b0, '0);
      step(1'b1, ALUFN_B,   1'b0, 8'hA5, 8'h0F, 1'b1, 1'b1, 8'hAF);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'hAA);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'h0F);
      drain();

      // stall with three ops offered, then release
      ops_f[0] = ALUFN_AND; ops_a[0] = 8'hF0; ops_b[0] = 8'h3C;
      ops_f[1] = ALUFN_OR;  ops_a[1] = 8'hA5; ops_b[1] = 8'h0F;
      ops_f[2] = ALUFN_XOR; ops_a[2] = 8'hA5; ops_b[2] = 8'h0F;
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         step(idx < 3, ops_f[idx % 3], 1'b0, ops_a[idx % 3], ops_b[idx % 3], 1'b0, 1'b0, '0);
         if (last_acc) idx++;
      end
      check("stall_accepted", idx, 2);
      for (int i = 0; i < 6 && idx < 3; i++) begin
         step(1'b1, ops_f[idx], 1'b0, ops_a[idx], ops_b[idx], 1'b1, 1'b0, '0);
         if (last_acc) idx++;
      end
      check("release_accepted", idx, 3);
      drain();

      // chained op directly after its predecessor
      step(1'b1, ALUFN_XOR, 1'b0, 8'hFF, 8'h0F, 1'b1, 1'b0, '0);
      step(1'b1, ALUFN_AND, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'hF0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'h30);
      drain();

      // chained op after predecessor has retired
      step(1'b1, ALUFN_XOR, 1'b0, 8'hFF, 8'h0F, 1'b1, 1'b0, '0);
      drain();
      step(1'b1, ALUFN_AND, 1'b1, 8'h55, 8'h3C, 1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'h30);
      drain();

      // flag cases
      step(1'b1, ALUFN_AND, 1'b0, 8'h0F, 8'hF0, 1'b1, 1'b0, '0);
      step(1'b1, ALUFN_OR,  1'b0, 8'h0F, 8'hF0, 1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'h00);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'hFF);
      drain();

      // reset with both stages full
      step(1'b1, ALUFN_OR,  1'b0, 8'h12, 8'h34, 1'b0, 1'b0, '0);
      step(1'b1, ALUFN_XOR, 1'b0, 8'h56, 8'h78, 1'b0, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b0, 1'b0, '0);
      rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_result", out_result, '0);
      q_res.delete();
      q_cyc.delete();
      m_acc = '0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, ALUFN_OR,  1'b1, 8'hFF, 8'h05, 1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b0, '0);
      step(1'b0, 4'h0,      1'b0, '0,    '0,    1'b1, 1'b1, 8'h05);
      drain();

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 9) < 7, 4'($urandom), 1'($urandom),
              W'($urandom), W'($urandom), $urandom_range(0, 9) < 7, 1'b0, '0);
      end
      drain();
      check("queue_empty", q_res.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
